// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared width, state and phase types for the SAR operand search
package sar_pkg;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        PROBE  = 1'b0,
        SAMPLE = 1'b1
    } phase_t;

endpackage

// File: rtl/sar_search_8.sv
// rtl/sar_search_8.sv - recovers a hidden comparator operand by MSB-first successive approximation
// SAR_SEARCH_PIPE_EN registers cmp_ge and splits each bit into PROBE/SAMPLE cycles
module sar_search_8 import sar_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] cmp_b,
    input  logic             cmp_ge,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] bit_q, bit_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] trial;
    logic             step;
    logic             ge_use;

`ifdef SAR_SEARCH_PIPE_EN
    phase_t phase_q, phase_d;
    logic   ge_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PROBE;
            ge_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ge_q    <= cmp_ge;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            bit_q    <= IDX_W'(WIDTH - 1);
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            result_q <= result_d;
        end
    end

    // The trial only differs from result_q in the bit under test, so it doubles as the accepted value
    assign trial = result_q | (WIDTH'(1) << bit_q);

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        result_d = result_q;
        step     = 1'b0;
        ge_use   = 1'b0;
`ifdef SAR_SEARCH_PIPE_EN
        phase_d  = phase_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SEARCH;
                    bit_d    = IDX_W'(WIDTH - 1);
                    result_d = '0;
`ifdef SAR_SEARCH_PIPE_EN
                    phase_d  = PROBE;
`endif
                end
            end
            SEARCH: begin
`ifdef SAR_SEARCH_PIPE_EN
                if (phase_q == PROBE) begin
                    phase_d = SAMPLE;
                end else begin
                    phase_d = PROBE;
                    step    = 1'b1;
                    ge_use  = ge_q;
                end
`else
                step   = 1'b1;
                ge_use = cmp_ge;
`endif
                if (step) begin
                    if (ge_use) begin
                        result_d = trial;
                    end
                    if (bit_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q - IDX_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmp_b  = (state_q == SEARCH) ? trial : '0;
    assign result = result_q;
    assign busy   = (state_q == SEARCH);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_sar_search_8.sv
// tb/tb_sar_search_8.sv - directed bench for sar_search_8 against a behavioural a>=b comparator
module tb_sar_search_8;

`ifdef SAR_SEARCH_PIPE_EN
    localparam int CPB = 2;
`else
    localparam int CPB = 1;
`endif
    localparam int PER = 8 * CPB + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] cmp_b;
    logic       cmp_ge;
    logic [7:0] result;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    sar_search_8 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp_b  (cmp_b),
        .cmp_ge (cmp_ge),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    assign cmp_ge = (a >= cmp_b);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // trials packs the eight expected cmp_b values, MSB trial in the top byte
    task automatic run(input logic [7:0] val, input logic [63:0] trials, input bit repulse);
        logic [63:0] tr;
        int          cyc;
        tr    = trials;
        a     = val;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        for (int k = 0; k < 8; k++) begin
            for (int p = 0; p < CPB; p++) begin
                chk("trial_cmp_b", cmp_b, tr[63-8*k -: 8]);
                chk("search_busy", busy, 1);
                chk("search_done", done, 0);
                start = repulse && (cyc == 3);
                tick();
                start = 1'b0;
                cyc++;
            end
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_result", result, val);
        chk("done_cmp_b", cmp_b, 0);
        start = repulse;
        tick();
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_hold", result, val);
        tick();
        chk("no_queue_busy", busy, 0);
    endtask

    initial begin
        int last;
        int cyc;
        int w;
        int nodone;

        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        @(negedge clk);
        start = 1'b1;
        tick();
        tick();
        chk("rst_result", result, 0);
        chk("rst_cmp_b", cmp_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        run(8'hA5, 64'h80C0A0B0A8A4A6A5, 1'b0);
        run(8'h00, 64'h8040201008040201, 1'b0);
        run(8'hFF, 64'h80C0E0F0F8FCFEFF, 1'b0);
        run(8'h3C, 64'h804020303838_3E3D & 64'h0 | 64'h8040203038_3C3E3D, 1'b1);
        run(8'h81, 64'h80C0A09088848281, 1'b0);

        a     = 8'h7E;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_result", result, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_cmp_b", cmp_b, 0);
        nodone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) nodone++;
            tick();
        end
        chk("abort_no_done", nodone, 0);
        run(8'h7E, 64'h80406070787C7E7F, 1'b0);

        a     = 8'h00;
        start = 1'b1;
        last  = -1;
        cyc   = 0;
        for (int v = 0; v < 256; v++) begin
            w = 0;
            while (done !== 1'b1 && w < 4 * PER) begin
                tick();
                cyc++;
                w++;
            end
            chk("exh_done", done, 1);
            if (done !== 1'b1) break;
            chk("exh_result", result, v[7:0]);
            if (last >= 0) chk("exh_gap", cyc - last, PER);
            last = cyc;
            a    = 8'(v + 1);
            tick();
            cyc++;
        end
        start = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
